// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, default address
// width and reset vector (also used by the decode stage), and a
// saturating increment helper for the optional statistics counters.
package cpu_fetch_pkg;

  localparam int          DEFAULT_ADDR_W     = 32;
  localparam logic [63:0] DEFAULT_RESET_ADDR = 64'h0;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_MISS = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// Holds a branch redirect that arrived while an I-cache refill was in
// progress. A newer redirect overwrites an older one (latest wins); the
// buffer is emptied when the refill completes and the redirect is applied.
module fetch_redirect_buf
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target_in,
  output logic              pending,
  output logic [ADDR_W-1:0] pend_target
);

  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] target_q, target_d;

  // Capture overwrites any earlier redirect; clear drops the buffered one.
  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    if (capture) begin
      pending_d = 1'b1;
      target_d  = target_in;
    end else if (clear) begin
      pending_d = 1'b0;
    end
  end

  // Buffer registers, fully reset so no X can leak into the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      target_q  <= '0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  assign pending     = pending_q;
  assign pend_target = target_q;

endmodule

// File: rtl/fetch_addr_gen.sv
// Fetch-address generator: registered PC stepping by STEP, stalling on
// I-cache miss or hazard stall, with buffered redirects during refills
// and a sticky miss watchdog.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_addr_gen
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned       STEP         = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR   = ADDR_W'(DEFAULT_RESET_ADDR),
  parameter int                MISS_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic              stall,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] adr_branch,
  output logic [ADDR_W-1:0] Ins_address,
  output logic [ADDR_W-1:0] Add_out,
  output logic              fetch_valid,
  output logic              redirect_pending,
`ifdef FETCH_STATS_EN
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_miss_cycles,
  output logic [31:0]       stat_redirects,
`endif
  output logic              miss_timeout
);

  localparam int         CNT_W  = $clog2(MISS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MISS_TIMEOUT);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              miss_timeout_q, miss_timeout_d;
  logic              redirect_apply;
  logic              buf_pending;
  logic [ADDR_W-1:0] buf_target;

  assign Add_out = pc_q + ADDR_W'(STEP);

  // Redirects seen while the line is missing are parked until the refill ends.
  fetch_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk        (clk),
    .rst        (rst),
    .capture    (PCSrc & ~hit),
    .clear      ((state_q == FETCH_MISS) & hit),
    .target_in  (adr_branch),
    .pending    (buf_pending),
    .pend_target(buf_target)
  );

  // Next PC, state and watchdog; a miss always wins over redirect and stall.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    miss_cnt_d     = miss_cnt_q;
    miss_timeout_d = miss_timeout_q;
    redirect_apply = 1'b0;
    case (state_q)
      FETCH_RUN: begin
        if (!hit) begin
          state_d    = FETCH_MISS;
          miss_cnt_d = CNT_W'(1);
        end else if (PCSrc) begin
          pc_d           = adr_branch;
          redirect_apply = 1'b1;
        end else if (!stall) begin
          pc_d = Add_out;
        end
      end
      FETCH_MISS: begin
        if (hit) begin
          state_d    = FETCH_RUN;
          miss_cnt_d = '0;
          if (PCSrc) begin
            pc_d           = adr_branch;
            redirect_apply = 1'b1;
          end else if (buf_pending) begin
            pc_d           = buf_target;
            redirect_apply = 1'b1;
          end else if (!stall) begin
            pc_d = Add_out;
          end
        end else if (miss_cnt_q != CNT_MAX) begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = FETCH_RUN;
    endcase
    if ((state_d == FETCH_MISS) && (miss_cnt_d == CNT_MAX)) begin
      miss_timeout_d = 1'b1;
    end
  end

  // Core fetch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FETCH_RUN;
      pc_q           <= RESET_ADDR;
      miss_cnt_q     <= '0;
      miss_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      miss_cnt_q     <= miss_cnt_d;
      miss_timeout_q <= miss_timeout_d;
    end
  end

  assign Ins_address      = pc_q;
  assign fetch_valid      = (state_q == FETCH_RUN) & hit & ~stall;
  assign redirect_pending = buf_pending;
  assign miss_timeout     = miss_timeout_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] miss_cyc_q, miss_cyc_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  // Saturating event counters for performance analysis.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    miss_cyc_d  = miss_cyc_q;
    redir_cnt_d = redir_cnt_q;
    if ((state_q == FETCH_RUN) && hit && stall) stall_cnt_d = sat_inc32(stall_cnt_q);
    if (state_q == FETCH_MISS) miss_cyc_d = sat_inc32(miss_cyc_q);
    if (redirect_apply) redir_cnt_d = sat_inc32(redir_cnt_q);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      miss_cyc_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      miss_cyc_q  <= miss_cyc_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_miss_cycles  = miss_cyc_q;
  assign stat_redirects    = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Self-checking bench for fetch_addr_gen: directed scenarios followed by
// random stimulus, compared against a behavioural model of the fetch rules.
// Statistics outputs are checked when FETCH_STATS_EN is defined.
module tb_fetch_addr_gen;

  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hit = 1'b1;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] adr_branch = '0;
  logic [31:0] Ins_address;
  logic [31:0] Add_out;
  logic        fetch_valid;
  logic        redirect_pending;
  logic        miss_timeout;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_stall_cycles, stat_miss_cycles, stat_redirects;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  bit          m_in_miss;
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_miss_len;
  bit          m_to;
  int          m_stalls, m_misses, m_redirs;

  fetch_addr_gen #(
    .MISS_TIMEOUT(MT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hit             (hit),
    .stall           (stall),
    .PCSrc           (PCSrc),
    .adr_branch      (adr_branch),
    .Ins_address     (Ins_address),
    .Add_out         (Add_out),
    .fetch_valid     (fetch_valid),
    .redirect_pending(redirect_pending),
`ifdef FETCH_STATS_EN
    .stat_stall_cycles(stat_stall_cycles),
    .stat_miss_cycles (stat_miss_cycles),
    .stat_redirects   (stat_redirects),
`endif
    .miss_timeout    (miss_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model for the inputs now applied.
  task automatic check_all();
    check_output("ins_address", Ins_address, m_pc);
    check_output("add_out", Add_out, m_pc + 32'd1);
    check_output("fetch_valid", {31'd0, fetch_valid}, {31'd0, (!m_in_miss && hit && !stall)});
    check_output("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
    check_output("miss_timeout", {31'd0, miss_timeout}, {31'd0, m_to});
`ifdef FETCH_STATS_EN
    check_output("stat_stall", stat_stall_cycles, m_stalls);
    check_output("stat_miss", stat_miss_cycles, m_misses);
    check_output("stat_redir", stat_redirects, m_redirs);
`endif
  endtask

  // Advance the model by one clock edge using the fetch rules.
  task automatic model_step(input bit r, input bit h, input bit s, input bit p, input logic [31:0] br);
    if (r) begin
      m_pc = 32'h0; m_in_miss = 0; m_pend = 0; m_tgt = 0; m_miss_len = 0; m_to = 0;
      m_stalls = 0; m_misses = 0; m_redirs = 0;
    end else if (!m_in_miss) begin
      if (h && s) m_stalls++;
      if (!h) begin
        m_in_miss = 1;
        m_miss_len = 1;
        if (m_miss_len >= MT) m_to = 1;
        if (p) begin m_pend = 1; m_tgt = br; end
      end else if (p) begin
        m_pc = br; m_redirs++;
      end else if (!s) begin
        m_pc = m_pc + 32'd1;
      end
    end else begin
      m_misses++;
      if (!h) begin
        if (m_miss_len < MT) m_miss_len++;
        if (m_miss_len >= MT) m_to = 1;
        if (p) begin m_pend = 1; m_tgt = br; end
      end else begin
        m_in_miss = 0;
        m_miss_len = 0;
        if (p) begin m_pc = br; m_pend = 0; m_redirs++; end
        else if (m_pend) begin m_pc = m_tgt; m_pend = 0; m_redirs++; end
        else if (!s) m_pc = m_pc + 32'd1;
      end
    end
  endtask

  // Drive one cycle of inputs, check outputs, then let the edge happen.
  task automatic apply_stimulus(input bit r, input bit h, input bit s, input bit p, input logic [31:0] br);
    @(negedge clk);
    rst = r; hit = h; stall = s; PCSrc = p; adr_branch = br;
    #1;
    if (!r) check_all();
    model_step(r, h, s, p, br);
  endtask

  // Move just past the next rising edge to look at registered results.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_step(1, 1, 0, 0, 0);

    // Reset, then sequential fetch.
    apply_stimulus(1, 1, 0, 0, 32'h0);
    settle();
    check_output("reset_pc", Ins_address, 32'h0);
    check_output("reset_timeout", {31'd0, miss_timeout}, 32'h0);
    check_output("reset_pending", {31'd0, redirect_pending}, 32'h0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 0, 32'h0);
    settle();
    check_output("seq_pc4", Ins_address, 32'h4);
    check_output("seq_add5", Add_out, 32'h5);

    // Plain miss at 0x10 resumes sequentially.
    apply_stimulus(0, 1, 0, 1, 32'h10);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 32'h0);
    settle();
    check_output("miss_hold", Ins_address, 32'h10);
    apply_stimulus(0, 1, 0, 0, 32'h0);
    settle();
    check_output("miss_resume", Ins_address, 32'h11);
    check_output("miss_no_timeout", {31'd0, miss_timeout}, 32'h0);

    // Redirects during a miss at 0x20: latest one wins.
    apply_stimulus(0, 1, 0, 1, 32'h20);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    apply_stimulus(0, 0, 0, 1, 32'h80);
    settle();
    check_output("pend_set", {31'd0, redirect_pending}, 32'h1);
    apply_stimulus(0, 0, 0, 1, 32'h90);
    apply_stimulus(0, 1, 0, 0, 32'h0);
    check_output("pend_fv0", {31'd0, fetch_valid}, 32'h0);
    settle();
    check_output("pend_pc", Ins_address, 32'h90);
    check_output("pend_clr", {31'd0, redirect_pending}, 32'h0);

    // Redirect beats stall, then stall holds.
    apply_stimulus(0, 1, 0, 1, 32'h30);
    apply_stimulus(0, 1, 1, 1, 32'h100);
    settle();
    check_output("stall_redir", Ins_address, 32'h100);
    apply_stimulus(0, 1, 1, 0, 32'h0);
    apply_stimulus(0, 1, 1, 0, 32'h0);
    settle();
    check_output("stall_hold", Ins_address, 32'h100);

    // Watchdog: rises after the 4th miss cycle, sticky until reset.
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 32'h0);
    settle();
    check_output("wd_before", {31'd0, miss_timeout}, 32'h0);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    settle();
    check_output("wd_rise", {31'd0, miss_timeout}, 32'h1);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    apply_stimulus(0, 1, 0, 0, 32'h0);
    settle();
    check_output("wd_sticky", {31'd0, miss_timeout}, 32'h1);
    apply_stimulus(1, 1, 0, 0, 32'h0);
    settle();
    check_output("wd_clear", {31'd0, miss_timeout}, 32'h0);
    check_output("wd_reset_pc", Ins_address, 32'h0);

    // PC wrap-around.
    apply_stimulus(0, 1, 0, 1, 32'hFFFF_FFFF);
    settle();
    check_output("wrap_add", Add_out, 32'h0);
    apply_stimulus(0, 1, 0, 0, 32'h0);
    settle();
    check_output("wrap_pc", Ins_address, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      apply_stimulus($urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 20,
                     $urandom);
    end
    apply_stimulus(0, 1, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
